// File: rtl/dataflow_pkg.sv
// Shared definitions for the dataflow stream blocks.
//   DataWidthDefault : default token width
//   data_t           : signed token at the default width
//   buf_state_e      : occupancy class of an elastic buffer
//   ptr_width()      : pointer width for a given depth (clog2)
package dataflow_pkg;

  localparam int unsigned DataWidthDefault = 32;

  typedef logic signed [DataWidthDefault-1:0] data_t;

  typedef enum logic [1:0] {
    StEmpty,
    StPartial,
    StFull
  } buf_state_e;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/dataflow_buffer_storage.sv
// Register array backing the elastic buffer. Contents are not reset.
//   clock : rising-edge clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address (asynchronous read)
//   rdata : read data
module dataflow_buffer_storage
  import dataflow_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DataWidthDefault,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned AW         = ptr_width(DEPTH)
) (
  input  logic                         clock,
  input  logic                         we,
  input  logic [AW-1:0]                waddr,
  input  logic signed [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]                raddr,
  output logic signed [DATA_WIDTH-1:0] rdata
);

  logic signed [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dataflow_buffer.sv
// Elastic FIFO stage decoupling a dataflow producer from its consumer.
// One cycle of forward latency; upstream ready depends only on registered
// occupancy (and reset), never on downstream ready.
//   clock : rising-edge clock
//   reset : synchronous active-high reset
//   arg0  : upstream data token
//   arg1  : upstream valid
//   arg2  : downstream ready
//   ret0  : ready to upstream
//   ret1  : data token to downstream (zero when not valid)
//   ret2  : valid to downstream
module dataflow_buffer
  import dataflow_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DataWidthDefault,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic signed [DATA_WIDTH-1:0] arg0,
  input  logic                         arg1,
  input  logic                         arg2,
  output logic                         ret0,
  output logic signed [DATA_WIDTH-1:0] ret1,
  output logic                         ret2
);

  localparam int unsigned PtrW = ptr_width(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  buf_state_e state;
  logic       enq, deq;
  logic signed [DATA_WIDTH-1:0] head;

  // Occupancy class decoded from the registered count.
  always_comb begin
    state = StPartial;
    if (count_q == '0) begin
      state = StEmpty;
    end else if (count_q == CntFull) begin
      state = StFull;
    end
  end

  assign ret0 = (state != StFull) && !reset;
  assign ret2 = (state != StEmpty);
  assign ret1 = ret2 ? head : '0;

  assign enq = arg1 && ret0;
  assign deq = ret2 && arg2;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (enq) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (deq) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({enq, deq})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  dataflow_buffer_storage #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (PtrW)
  ) u_storage (
    .clock (clock),
    .we    (enq),
    .waddr (wr_ptr_q),
    .wdata (arg0),
    .raddr (rd_ptr_q),
    .rdata (head)
  );

endmodule

// File: tb/tb_dataflow_buffer.sv
// Directed bench for dataflow_buffer with a queue scoreboard of expected tokens.
module tb_dataflow_buffer;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;

  logic                 clock = 1'b0;
  logic                 reset;
  logic signed [DW-1:0] arg0;
  logic                 arg1;
  logic                 arg2;
  logic                 ret0;
  logic signed [DW-1:0] ret1;
  logic                 ret2;

  int checks   = 0;
  int failures = 0;

  logic signed [DW-1:0] sb [$];

  always #5 clock = ~clock;

  dataflow_buffer #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) dut (
    .clock (clock),
    .reset (reset),
    .arg0  (arg0),
    .arg1  (arg1),
    .arg2  (arg2),
    .ret0  (ret0),
    .ret1  (ret1),
    .ret2  (ret2)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  // Drive one cycle, check outputs mid-cycle against the model, then advance
  // the model with the handshakes the model itself predicts.
  task automatic step(input string tag, input logic signed [DW-1:0] d, input logic v,
                      input logic r, input logic rs);
    logic                 e_ret0, e_ret2;
    logic signed [DW-1:0] e_ret1;
    arg0  = d;
    arg1  = v;
    arg2  = r;
    reset = rs;
    @(negedge clock);
    e_ret0 = !rs && (sb.size() < DEPTH);
    e_ret2 = (sb.size() != 0);
    e_ret1 = e_ret2 ? sb[0] : '0;
    chk({tag, ".ret0"}, {31'd0, ret0}, {31'd0, e_ret0});
    chk({tag, ".ret2"}, {31'd0, ret2}, {31'd0, e_ret2});
    chk({tag, ".ret1"}, ret1, e_ret1);
    @(posedge clock);
    if (rs) begin
      sb.delete();
    end else begin
      if (e_ret2 && r) void'(sb.pop_front());
      if (v && e_ret0) sb.push_back(d);
    end
    #1;
  endtask

  initial begin
    arg0  = '0;
    arg1  = 1'b0;
    arg2  = 1'b0;
    reset = 1'b1;
    @(posedge clock);
    #1;

    // Reset held, then idle.
    step("rst0", 0, 1'b0, 1'b0, 1'b1);
    step("rst1", 0, 1'b1, 1'b1, 1'b1);
    step("idle", 0, 1'b0, 1'b0, 1'b0);

    // Single token.
    step("one_push", -5, 1'b1, 1'b1, 1'b0);
    step("one_out", 0, 1'b0, 1'b1, 1'b0);
    step("one_gone", 0, 1'b0, 1'b1, 1'b0);

    // Fill to full, fifth push rejected.
    step("fill10", 10, 1'b1, 1'b0, 1'b0);
    step("fill20", 20, 1'b1, 1'b0, 1'b0);
    step("fill30", 30, 1'b1, 1'b0, 1'b0);
    step("fill40", 40, 1'b1, 1'b0, 1'b0);
    step("fill50", 50, 1'b1, 1'b0, 1'b0);

    // Full with simultaneous request: dequeue only.
    step("full_req", 99, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step("drain", 0, 1'b0, 1'b1, 1'b0);

    // Streaming.
    for (int i = 0; i < 16; i++) step("stream", i, 1'b1, 1'b1, 1'b0);
    step("stream_tail", 0, 1'b0, 1'b1, 1'b0);
    step("stream_idle", 0, 1'b0, 1'b1, 1'b0);

    // Hold head under backpressure.
    step("hold_push", 123, 1'b1, 1'b0, 1'b0);
    step("hold1", 0, 1'b0, 1'b0, 1'b0);
    step("hold2", 0, 1'b0, 1'b0, 1'b0);
    step("hold_rel", 0, 1'b0, 1'b1, 1'b0);

    // Reset mid-operation discards contents.
    step("mid7", 7, 1'b1, 1'b0, 1'b0);
    step("mid8", 8, 1'b1, 1'b0, 1'b0);
    step("mid9", 9, 1'b1, 1'b0, 1'b0);
    step("mid_rst", 0, 1'b0, 1'b0, 1'b1);
    step("post100", 100, 1'b1, 1'b0, 1'b0);
    step("post_out", 0, 1'b0, 1'b1, 1'b0);
    step("post_empty", 0, 1'b0, 1'b1, 1'b0);

    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
